// File: rtl/subtrator_serial.sv
// subtrator_serial: bit-serial N-bit subtractor, diff = a - b (mod 2^N).
// One full-subtractor cell and a borrow flop process one bit per clock,
// LSB first. A start/busy/done handshake drives it from a controlling FSM.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous reset, active low
//   start  in   request, sampled only in IDLE or DONE
//   a, b   in   N-bit minuend / subtrahend, captured on accepted start
//   busy   out  high while bits are being shifted
//   done   out  one-cycle pulse when diff/bout are valid
//   diff   out  N-bit result, held until the next completed operation
//   bout   out  final borrow (a < b unsigned), held with diff
//   ovf    out  signed overflow, only when SUBTRATOR_OVERFLOW_EN is defined
//
// Optional feature macro: SUBTRATOR_OVERFLOW_EN (adds the ovf port).
module subtrator_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
`ifdef SUBTRATOR_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic [N-1:0]   diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d;
  logic           busy_q, busy_d, done_q, done_d, bout_q, bout_d;
`ifdef SUBTRATOR_OVERFLOW_EN
  // Operand sign bits are shifted out of ra/rb, so keep them for ovf.
  logic           am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs.
  logic           a0, b0, d_bit, br_nxt;
  logic [N:0]     rd_ext;

  assign a0     = ra_q[0];
  assign b0     = rb_q[0];
  assign d_bit  = a0 ^ b0 ^ br_q;
  assign br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  // New bit enters at the MSB; taking [N:1] also covers N == 1.
  assign rd_ext = {d_bit, rd_q};

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SUBTRATOR_OVERFLOW_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SUBTRATOR_OVERFLOW_EN
          am_d    = a[N-1];
          bm_d    = b[N-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        rd_d  = rd_ext[N:1];
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Publish on the final bit so diff/bout never show partial results.
          state_d = DONE;
          diff_d  = rd_ext[N:1];
          bout_d  = br_nxt;
`ifdef SUBTRATOR_OVERFLOW_EN
          ovf_d   = (am_q != bm_q) && (d_bit != am_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUBTRATOR_OVERFLOW_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUBTRATOR_OVERFLOW_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUBTRATOR_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_subtrator_serial.sv
// Testbench for subtrator_serial: N=8 instance plus an N=1 instance.
// Expected results come from plain integer arithmetic on the operands.
module tb_subtrator_serial;
  localparam int N = 8;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic         busy, done, bout;
  logic [N-1:0] diff;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0, b1 = '0;
  logic         busy1, done1, bout1;
  logic [0:0]   diff1;
`ifdef SUBTRATOR_OVERFLOW_EN
  logic         ovf, ovf1;
`endif

  int vectors = 0, miscompares = 0;
  logic [N-1:0] exp_diff = '0, hold_diff = '0;
  logic         exp_bout = 1'b0, hold_bout = 1'b0;
  logic         exp_ovf = 1'b0, hold_ovf = 1'b0;

  subtrator_serial #(.N(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SUBTRATOR_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  subtrator_serial #(.N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SUBTRATOR_OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned modular difference, borrow = a < b, signed overflow
  // = true signed difference outside the N-bit two's-complement range.
  task automatic model(input logic [N-1:0] av, input logic [N-1:0] bv);
    int r, sr;
    r  = int'(av) - int'(bv);
    sr = int'($signed(av)) - int'($signed(bv));
    exp_diff = N'(r);
    exp_bout = (r < 0);
    exp_ovf  = (sr > 127) || (sr < -128);
  endtask

  // Drive a request; the next rising edge accepts it.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv);
    start = 1'b1;
    a = av;
    b = bv;
    model(av, bv);
  endtask

  // N busy cycles; outputs must hold the previous result throughout.
  task automatic shift_phase(input bit toggle);
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("diff_stable", diff, hold_diff);
      chk("bout_stable", bout, hold_bout);
      start = toggle ? k[0] : 1'b0;
      a = N'($urandom);
      b = N'($urandom);
    end
  endtask

  task automatic done_phase();
    @(negedge clk);
    chk("done", done, 1);
    chk("busy_low", busy, 0);
    chk("diff", diff, exp_diff);
    chk("bout", bout, exp_bout);
`ifdef SUBTRATOR_OVERFLOW_EN
    chk("ovf", ovf, exp_ovf);
`endif
    hold_diff = exp_diff;
    hold_bout = exp_bout;
    hold_ovf  = exp_ovf;
  endtask

  task automatic idle_check();
    start = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_diff", diff, hold_diff);
    chk("idle_bout", bout, hold_bout);
  endtask

  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv);
    @(negedge clk);
    issue(av, bv);
    shift_phase(1'b0);
    done_phase();
    idle_check();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_diff1", diff1, 0);
    rst_n = 1'b1;

    // Directed cases
    run_op(8'd100, 8'd25);
    run_op(8'd25, 8'd100);
    run_op(8'h00, 8'h01);
    run_op(8'h00, 8'h00);
    run_op(8'h80, 8'h01);
    run_op(8'h7F, 8'h01);
    run_op(8'hFF, 8'hFF);

    // Random operands
    for (int i = 0; i < 20; i++) run_op(N'($urandom), N'($urandom));

    // Back-to-back: second request accepted in the DONE cycle, start
    // toggling during SHIFT must not restart the operation.
    @(negedge clk);
    issue(8'd10, 8'd3);
    shift_phase(1'b1);
    done_phase();
    issue(8'd9, 8'd9);
    shift_phase(1'b1);
    done_phase();
    idle_check();

    // Reset in the 4th SHIFT cycle discards the operation.
    @(negedge clk);
    issue(8'hC3, 8'h5A);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4) rst_n = 1'b0;
    end
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bout", bout, 0);
`ifdef SUBTRATOR_OVERFLOW_EN
    chk("mid_rst_ovf", ovf, 0);
`endif
    hold_diff = '0;
    hold_bout = 1'b0;
    hold_ovf  = 1'b0;
    rst_n = 1'b1;
    run_op(8'h3C, 8'h0F);

    // N=1 instance: 0 - 1 -> diff 1, borrow 1, done two cycles after start.
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("n1_busy", busy1, 1);
    chk("n1_done_low", done1, 0);
    @(negedge clk);
    chk("n1_done", done1, 1);
    chk("n1_diff", diff1, 1);
    chk("n1_bout", bout1, 1);
`ifdef SUBTRATOR_OVERFLOW_EN
    chk("n1_ovf", ovf1, 1);
`endif
    @(negedge clk);
    chk("n1_idle", done1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
